// File: rtl/sha256_block_feeder_if.sv
`default_nettype none
// ============================================================================
// sha256_block_feeder_if : request bus and compression-core bus of the feeder
// Revision 1.0
// ============================================================================
// Multi-word fields are packed with word 0 in the most significant bits.
interface sha256_block_feeder_if #(
    parameter int NUM_OF_WORDS = 20
);
    logic                      start;
    logic [32*NUM_OF_WORDS-1:0] message;
    logic                      busy;
    logic                      done;
    logic [255:0]              digest;
    logic                      core_start;
    logic [511:0]              core_message;
    logic [255:0]              core_hin;
    logic [255:0]              core_hout;
    logic                      core_done;

    modport master (
        output start, message, core_hout, core_done,
        input  busy, done, digest, core_start, core_message, core_hin
    );

    modport slave (
        input  start, message, core_hout, core_done,
        output busy, done, digest, core_start, core_message, core_hin
    );
endinterface
`default_nettype wire

// File: rtl/sha256_block_feeder.sv
`default_nettype none
// ============================================================================
// sha256_block_feeder : pads a fixed-length message and chains its blocks
//                       through a SHA-256 compression core
// Revision 1.0
// ============================================================================
module sha256_block_feeder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    sha256_block_feeder_if.slave bus
);
    localparam int             NB       = (NUM_OF_WORDS + 18) / 16;
    localparam int             MW       = 32 * NUM_OF_WORDS;
    localparam logic [7:0]     LAST_BLK = 8'(NB - 1);
    localparam logic [31:0]    LEN_BITS = 32'(NUM_OF_WORDS * 32);
    localparam logic [255:0]   H_INIT   = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BUILD = 3'd1;
    localparam logic [2:0] S_KICK  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [MW-1:0] msg_q;
    logic [7:0]    blk_q;
    logic [511:0]  core_msg_q;
    logic [511:0]  core_msg_d;
    logic [255:0]  core_hin_q;
    logic [255:0]  core_hin_d;
    logic [255:0]  chain_q;
    logic [255:0]  digest_q;

    // Word p of the padded stream; the upper 32 bits of the length are always zero.
    function automatic logic [31:0] pad_word(input logic [MW-1:0] m, input int p);
        logic [31:0] w;
        w = 32'h0;
        if (p < NUM_OF_WORDS) begin
            w = m[MW-1-32*p -: 32];
        end else if (p == NUM_OF_WORDS) begin
            w = 32'h8000_0000;
        end else if (p == 16*NB-1) begin
            w = LEN_BITS;
        end
        return w;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_BUILD;
            S_BUILD: state_d = S_KICK;
            S_KICK:  state_d = S_WAIT;
            S_WAIT:  if (bus.core_done) state_d = (blk_q == LAST_BLK) ? S_FIN : S_BUILD;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state_q != S_IDLE);
        bus.done         = (state_q == S_FIN);
        bus.core_start   = (state_q == S_KICK);
        bus.digest       = digest_q;
        bus.core_message = core_msg_q;
        bus.core_hin     = core_hin_q;
    end

    always_comb begin
        core_msg_d = '0;
        for (int n = 0; n < 16; n++) begin
            core_msg_d[511-32*n -: 32] = pad_word(msg_q, 16*int'(blk_q) + n);
        end
        core_hin_d = (blk_q == 8'd0) ? H_INIT : chain_q;
    end

    // core_done only counts in WAIT, so a stale completion after reset is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_q      <= '0;
            blk_q      <= 8'd0;
            core_msg_q <= '0;
            core_hin_q <= '0;
            chain_q    <= '0;
            digest_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        msg_q <= bus.message;
                        blk_q <= 8'd0;
                    end
                end
                S_BUILD: begin
                    core_msg_q <= core_msg_d;
                    core_hin_q <= core_hin_d;
                end
                S_WAIT: begin
                    if (bus.core_done) begin
                        chain_q <= bus.core_hout;
                        if (blk_q == LAST_BLK) begin
                            digest_q <= bus.core_hout;
                        end else begin
                            blk_q <= blk_q + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
